// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch monitor: FSM encoding and parameter defaults.
package glitch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_ALARM    = 2'd2
  } state_e;

  localparam int CNT_W_DEF  = 8;
  localparam int THRESH_DEF = 4;
  localparam int HOLD_DEF   = 3;
  localparam int RUN_W      = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/glitch_monitor.sv
// Counts sustained low runs of the hazard-filter output and raises an alarm
// once the event count reaches THRESH; the alarm holds until clr or reset.
module glitch_monitor
  import glitch_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int THRESH = THRESH_DEF,
  parameter int HOLD   = HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             filt_in,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             irq,
  output logic [1:0]       state
);

  localparam logic [RUN_W-1:0] HOLD_C    = RUN_W'(HOLD);
  localparam logic [RUN_W-1:0] HOLD_M1   = RUN_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic             s;
  logic [RUN_W-1:0] run_q;
  logic             evt;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  state_e           state_q;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (filt_in),
    .q_o   (s)
  );

  // Run length saturates at HOLD so a long run matches HOLD-1 only once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q <= '0;
    end else if (s) begin
      run_q <= '0;
    end else if (run_q != HOLD_C) begin
      run_q <= run_q + RUN_W'(1);
    end
  end

  assign evt     = !s && (run_q == HOLD_M1);
  assign count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      state_q <= ST_IDLE;
    end else if (clr) begin
      count_q <= '0;
      state_q <= ST_IDLE;
    end else if (evt) begin
      count_q <= count_d;
      case (state_q)
        ST_IDLE:     state_q <= (count_d >= THRESH_C) ? ST_ALARM : ST_COUNTING;
        ST_COUNTING: state_q <= (count_d >= THRESH_C) ? ST_ALARM : ST_COUNTING;
        ST_ALARM:    state_q <= ST_ALARM;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign irq   = (state_q == ST_ALARM);

endmodule

// File: tb/tb_glitch_monitor.sv
// Self-checking bench: directed scenarios plus randomized stimulus against a
// run-length/event reference model, on a default instance and a narrow-counter one.
module tb_glitch_monitor;

  localparam int HOLD    = 3;
  localparam int THR1    = 4;
  localparam int MAX1    = 255;
  localparam int THR2    = 7;
  localparam int MAX2    = 7;

  logic       clk;
  logic       rst_n;
  logic       filt_in;
  logic       clr;
  logic [7:0] count1;
  logic       irq1;
  logic [1:0] state1;
  logic [2:0] count2;
  logic       irq2;
  logic [1:0] state2;

  int checks = 0;
  int errors = 0;

  // Reference model: sync delay as a queue of samples, low-run length as a plain integer
  bit q_hist[$];
  int lowlen;
  int m_cnt1;
  int m_cnt2;

  glitch_monitor #(.CNT_W(8), .THRESH(THR1), .HOLD(HOLD)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .filt_in (filt_in),
    .clr     (clr),
    .count   (count1),
    .irq     (irq1),
    .state   (state1)
  );

  glitch_monitor #(.CNT_W(3), .THRESH(THR2), .HOLD(HOLD)) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .filt_in (filt_in),
    .clr     (clr),
    .count   (count2),
    .irq     (irq2),
    .state   (state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_state(input int cnt, input int thr);
    if (cnt >= thr) return 2;
    if (cnt > 0)    return 1;
    return 0;
  endfunction

  task automatic model_step();
    bit s;
    bit ev;
    s = q_hist.pop_front();
    q_hist.push_back(filt_in);
    if (s == 1'b0) lowlen++;
    else           lowlen = 0;
    ev = (lowlen == HOLD);
    if (!rst_n) begin
      m_cnt1 = 0;
      m_cnt2 = 0;
      lowlen = 0;
      q_hist = {1'b1, 1'b1};
    end else if (clr) begin
      m_cnt1 = 0;
      m_cnt2 = 0;
    end else if (ev) begin
      m_cnt1 = (m_cnt1 < MAX1) ? m_cnt1 + 1 : MAX1;
      m_cnt2 = (m_cnt2 < MAX2) ? m_cnt2 + 1 : MAX2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_low(input int len);
    filt_in = 1'b0;
    repeat (len) tick();
    filt_in = 1'b1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clr = 1'b0;
    filt_in = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr = 1'b1;
    filt_in = 1'b0;
    repeat (2) tick();
    checks++;
    if (count1 !== 8'd0 || state1 !== 2'd0 || irq1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut1: got count=%0d state=%0d irq=%0d, expected 0/0/0", count1, state1, irq1);
    end
    checks++;
    if (count2 !== 3'd0 || state2 !== 2'd0 || irq2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut2: got count=%0d state=%0d irq=%0d, expected 0/0/0", count2, state2, irq2);
    end
    clr = 1'b0;
    filt_in = 1'b1;
    rst_n = 1'b1;
    repeat (3) tick();
    $display("test_reset done");
  endtask

  task automatic test_short_glitch();
    reset_dut();
    run_low(2);
    repeat (8) begin
      tick();
      checks++;
      if (count1 !== 8'd0 || state1 !== 2'd0) begin
        errors++;
        $display("FAIL short_glitch: got count=%0d state=%0d, expected 0/0", count1, state1);
      end
    end
    $display("test_short_glitch done");
  endtask

  task automatic test_min_event();
    reset_dut();
    filt_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 4) filt_in = 1'b1;
      tick();
      checks++;
      if (i < 5 && count1 !== 8'd0) begin
        errors++;
        $display("FAIL min_event_early edge%0d: got count=%0d, expected 0", i, count1);
      end else if (i == 5 && (count1 !== 8'd1 || state1 !== 2'd1)) begin
        errors++;
        $display("FAIL min_event_edge5: got count=%0d state=%0d, expected 1/1", count1, state1);
      end
    end
    repeat (3) tick();
    run_low(20);
    repeat (6) tick();
    checks++;
    if (count1 !== 8'd2 || state1 !== 2'd1) begin
      errors++;
      $display("FAIL long_run: got count=%0d state=%0d, expected 2/1", count1, state1);
    end
    $display("test_min_event done");
  endtask

  task automatic test_threshold();
    reset_dut();
    repeat (3) begin
      run_low(3);
      repeat (4) tick();
    end
    checks++;
    if (count1 !== 8'd3 || state1 !== 2'd1 || irq1 !== 1'b0) begin
      errors++;
      $display("FAIL thresh_pre: got count=%0d state=%0d irq=%0d, expected 3/1/0", count1, state1, irq1);
    end
    run_low(3);
    tick();
    checks++;
    if (irq1 !== 1'b0 || state1 !== 2'd1) begin
      errors++;
      $display("FAIL thresh_edge4: got state=%0d irq=%0d, expected 1/0", state1, irq1);
    end
    tick();
    checks++;
    if (count1 !== 8'd4 || state1 !== 2'd2 || irq1 !== 1'b1) begin
      errors++;
      $display("FAIL thresh_edge5: got count=%0d state=%0d irq=%0d, expected 4/2/1", count1, state1, irq1);
    end
    repeat (3) tick();
    run_low(3);
    repeat (4) tick();
    checks++;
    if (count1 !== 8'd5 || irq1 !== 1'b1 || state1 !== 2'd2) begin
      errors++;
      $display("FAIL fifth_event: got count=%0d state=%0d irq=%0d, expected 5/2/1", count1, state1, irq1);
    end
    $display("test_threshold done");
  endtask

  task automatic test_clr_collision();
    reset_dut();
    run_low(3);
    repeat (4) tick();
    run_low(3);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (count1 !== 8'd0 || state1 !== 2'd0 || irq1 !== 1'b0) begin
      errors++;
      $display("FAIL clr_collision: got count=%0d state=%0d irq=%0d, expected 0/0/0", count1, state1, irq1);
    end
    repeat (8) tick();
    checks++;
    if (count1 !== 8'd0 || state1 !== 2'd0) begin
      errors++;
      $display("FAIL clr_after: got count=%0d state=%0d, expected 0/0", count1, state1);
    end
    $display("test_clr_collision done");
  endtask

  task automatic test_clr_midrun();
    reset_dut();
    filt_in = 1'b0;
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (count1 !== 8'd0) begin
      errors++;
      $display("FAIL clr_midrun_edge4: got count=%0d, expected 0", count1);
    end
    tick();
    checks++;
    if (count1 !== 8'd1 || state1 !== 2'd1) begin
      errors++;
      $display("FAIL clr_midrun_edge5: got count=%0d state=%0d, expected 1/1", count1, state1);
    end
    repeat (10) tick();
    filt_in = 1'b1;
    repeat (4) tick();
    checks++;
    if (count1 !== 8'd1) begin
      errors++;
      $display("FAIL clr_midrun_once: got count=%0d, expected 1", count1);
    end
    $display("test_clr_midrun done");
  endtask

  task automatic test_saturation();
    reset_dut();
    repeat (9) begin
      run_low(3);
      repeat (4) tick();
    end
    checks++;
    if (count2 !== 3'd7 || irq2 !== 1'b1 || state2 !== 2'd2) begin
      errors++;
      $display("FAIL saturation_dut2: got count=%0d state=%0d irq=%0d, expected 7/2/1", count2, state2, irq2);
    end
    checks++;
    if (count1 !== 8'd9 || irq1 !== 1'b1) begin
      errors++;
      $display("FAIL saturation_dut1: got count=%0d irq=%0d, expected 9/1", count1, irq1);
    end
    $display("test_saturation done");
  endtask

  task automatic test_reset_midrun();
    reset_dut();
    filt_in = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (count1 !== 8'd0 || state1 !== 2'd0 || irq1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: got count=%0d state=%0d irq=%0d, expected 0/0/0", count1, state1, irq1);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (count1 !== ((i == 5) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("FAIL reset_midrun_edge%0d: got count=%0d, expected %0d", i, count1, (i == 5) ? 1 : 0);
      end
    end
    filt_in = 1'b1;
    $display("test_reset_midrun done");
  endtask

  task automatic test_random();
    int seg_left;
    int local_err;
    seg_left = 0;
    local_err = 0;
    reset_dut();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (seg_left == 0) begin
        filt_in = $urandom_range(0, 1);
        seg_left = $urandom_range(1, 8);
      end
      seg_left--;
      clr   = ($urandom_range(0, 29) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
      checks++;
      if (int'(count1) != m_cnt1 || int'(state1) != exp_state(m_cnt1, THR1) ||
          irq1 !== (m_cnt1 >= THR1)) begin
        errors++;
        local_err++;
        $display("FAIL random_dut1 cyc%0d: got count=%0d state=%0d irq=%0d, expected %0d/%0d/%0d",
                 cyc, count1, state1, irq1, m_cnt1, exp_state(m_cnt1, THR1), m_cnt1 >= THR1);
      end
      checks++;
      if (int'(count2) != m_cnt2 || int'(state2) != exp_state(m_cnt2, THR2) ||
          irq2 !== (m_cnt2 >= THR2)) begin
        errors++;
        local_err++;
        $display("FAIL random_dut2 cyc%0d: got count=%0d state=%0d irq=%0d, expected %0d/%0d/%0d",
                 cyc, count2, state2, irq2, m_cnt2, exp_state(m_cnt2, THR2), m_cnt2 >= THR2);
      end
      if (local_err > 20) break;
    end
    clr = 1'b0;
    rst_n = 1'b1;
    $display("test_random done");
  endtask

  initial begin
    q_hist = {1'b1, 1'b1};
    lowlen = 0;
    m_cnt1 = 0;
    m_cnt2 = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    filt_in = 1'b1;
    test_reset();
    test_short_glitch();
    test_min_event();
    test_threshold();
    test_clr_collision();
    test_clr_midrun();
    test_saturation();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/glitch_monitor.md
GLITCH_MONITOR -- requirements
Module: glitch_monitor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter CNT_W SHALL default to 8 and set the event-counter width.
REQ-003 Parameter THRESH SHALL default to 4 and set the event count at which the alarm is raised; legal range is 1..2^CNT_W-1.
REQ-004 Parameter HOLD SHALL default to 3 and set the minimum number of consecutive low synchronized samples that count as one event; legal range is 1..15.
REQ-005 Port clk SHALL be an input, 1 bit wide: rising-edge clock.
REQ-006 Port rst_n SHALL be an input, 1 bit wide: synchronous reset, active low.
REQ-007 Port filt_in SHALL be an input, 1 bit wide, asynchronous: the hazard-filter result (1 = clean, 0 = hazard flagged).
REQ-008 Port clr SHALL be an input, 1 bit wide: a one-cycle request that clears the count and the alarm.
REQ-009 Port count SHALL be an output, CNT_W bits wide: the number of events seen, saturating.
REQ-010 Port irq SHALL be an output, 1 bit wide: the alarm, high while the block is in state ALARM.
REQ-011 Port state SHALL be an output, 2 bits wide: the current FSM state (IDLE=0, COUNTING=1, ALARM=2).

Function
REQ-012 filt_in SHALL pass through a two-flop synchronizer; the second flop output s is the only internal use of filt_in.
REQ-013 A run counter (4 bits) SHALL increment at each edge where s=0 and clear to 0 at each edge where s=1.
REQ-014 An event SHALL occur at the edge where the HOLD-th consecutive low sample of s is taken; exactly one event SHALL occur per low run, whatever the run length.
REQ-015 Once the run counter reaches HOLD it SHALL saturate at HOLD rather than wrap.
REQ-016 On an event, count SHALL increment at that same edge, saturating at 2^CNT_W-1.
REQ-017 Latency: if filt_in goes low before edge 1 and stays low, count SHALL update at edge 2+HOLD.
REQ-018 FSM transitions:
- IDLE to COUNTING on an event when the new count is below THRESH.
- COUNTING to ALARM when the new count is at least THRESH.
- IDLE to ALARM directly when THRESH=1.
REQ-019 ALARM SHALL be left only by clr or reset; further events still increment count.
REQ-020 When clr=1 at an edge, count SHALL become 0 and state SHALL become IDLE at that edge, with irq low from that edge on.
REQ-021 If clr and an event coincide, clr SHALL win and the event SHALL be discarded.
REQ-022 clr SHALL NOT affect the synchronizer or the run counter; a low run in progress SHALL still produce at most one event, and only if HOLD is reached after the clear.
REQ-023 irq SHALL be decoded from the registered state only.

Reset
REQ-024 When rst_n=0 at an edge, the block SHALL set count=0, state=IDLE, irq=0 and the run counter to 0.
REQ-025 Reset SHALL set both synchronizer flops to 1 so that no spurious event follows reset.
REQ-026 Reset SHALL take priority over clr and over events.
REQ-027 Reset asserted mid-run SHALL abandon the run; a new event then requires 2+HOLD edges of low filt_in after rst_n is released.

Structure
REQ-028 Package glitch_pkg SHALL hold the state encoding and the default values of CNT_W, THRESH and HOLD.
REQ-029 The synchronizer SHALL be a separate sub-module, sync2 (1 bit, synchronous active-low reset, reset value a parameter), instantiated once.
REQ-030 The run counter, event detection, counter and FSM SHALL reside in glitch_monitor.

Verification (defaults CNT_W=8, THRESH=4, HOLD=3 unless noted)
REQ-031 Short glitch: filt_in low for 2 cycles, then high -> count stays 0 and state stays IDLE.
REQ-032 Minimum event and long run: filt_in low for 3 cycles -> count=1 and state=COUNTING at edge 5 after the fall. filt_in low for 20 cycles -> count increments exactly once.
REQ-033 Threshold: 4 separated events -> irq=1 and state=ALARM at the 4th event edge. A 5th event -> count=5, irq stays 1.
REQ-034 clr collision: clr pulsed on the edge of the 2nd event -> count=0, state=IDLE, and no increment follows.
REQ-035 Saturation: CNT_W=3, THRESH=7, 9 events -> count stays 7 and irq=1.
REQ-036 Reset mid-run: rst_n low for 1 cycle during a low run with filt_in held low -> all outputs 0, and the next count=1 occurs 5 edges after rst_n releases.
